// File: rtl/layer_mem_arb.sv
// Shared layer-memory port arbiter for the CONV5x5 flow.
// Requester 0 is the convolution engine and requester 1 is the pooling engine.
// Arbitration is burst-limited round-robin with at most one operation per cycle.
// All memory-side outputs are registered, and read data returns two edges after the accept.
module layer_mem_arb #(
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 13,
    parameter int unsigned BURST = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          r0_req_i,
    input  logic          r0_we_i,
    input  logic          r0_sel_i,
    input  logic [AW-1:0] r0_addr_i,
    input  logic [DW-1:0] r0_wdata_i,
    output logic          r0_gnt_o,
    output logic          r0_rvalid_o,
    input  logic          r1_req_i,
    input  logic          r1_we_i,
    input  logic          r1_sel_i,
    input  logic [AW-1:0] r1_addr_i,
    input  logic [DW-1:0] r1_wdata_i,
    output logic          r1_gnt_o,
    output logic          r1_rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic          crd_o,
    output logic          cwr_o,
    output logic          csel_o,
    output logic [AW-1:0] caddr_rd_o,
    output logic [AW-1:0] caddr_wr_o,
    output logic [DW-1:0] cdata_wr_o,
    input  logic [DW-1:0] cdata_rd_i
);

    localparam logic [3:0] BurstMax = 4'(BURST);

    logic          prio_q, prio_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          pend_v_q, pend_id_q;
    logic          r0_rvalid_q, r1_rvalid_q;
    logic [DW-1:0] rdata_q;
    logic          crd_q, cwr_q, csel_q;
    logic [AW-1:0] caddr_rd_q, caddr_wr_q;
    logic [DW-1:0] cdata_wr_q;

    logic          gnt0, gnt1, acc, acc_id, pick;
    logic          acc_we, acc_sel;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    // Grant decision: a lone requester always wins; under contention prio keeps
    // the port until it has used BURST consecutive grants.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        pick = prio_q;
        if (r0_req_i && r1_req_i) begin
            pick = (cnt_q < BurstMax) ? prio_q : ~prio_q;
            gnt1 = pick;
            gnt0 = ~pick;
        end else begin
            gnt0 = r0_req_i;
            gnt1 = r1_req_i;
        end
    end

    assign acc      = gnt0 | gnt1;
    assign acc_id   = gnt1;
    assign acc_we    = acc_id ? r1_we_i    : r0_we_i;
    assign acc_sel   = acc_id ? r1_sel_i   : r0_sel_i;
    assign acc_addr  = acc_id ? r1_addr_i  : r0_addr_i;
    assign acc_wdata = acc_id ? r1_wdata_i : r0_wdata_i;

    // Next priority/burst count: saturate on repeat grants, restart on a handover,
    // clear on an idle cycle.
    always_comb begin
        prio_d = prio_q;
        cnt_d  = cnt_q;
        if (!acc) begin
            cnt_d = 4'd0;
        end else if (acc_id == prio_q) begin
            if (cnt_q < BurstMax) cnt_d = cnt_q + 4'd1;
        end else begin
            prio_d = acc_id;
            cnt_d  = 4'd1;
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            prio_q <= prio_d;
            cnt_q  <= cnt_d;
        end
    end

    // Registered memory command; address, select and write data hold when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
        end else begin
            crd_q <= acc & ~acc_we;
            cwr_q <= acc & acc_we;
            if (acc) begin
                csel_q <= acc_sel;
                if (acc_we) begin
                    caddr_wr_q <= acc_addr;
                    cdata_wr_q <= acc_wdata;
                end else begin
                    caddr_rd_q <= acc_addr;
                end
            end
        end
    end

    // Read-tag pipeline: capture memory data one edge after issue and steer rvalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_v_q    <= 1'b0;
            pend_id_q   <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            pend_v_q    <= acc & ~acc_we;
            if (acc) pend_id_q <= acc_id;
            r0_rvalid_q <= pend_v_q & ~pend_id_q;
            r1_rvalid_q <= pend_v_q & pend_id_q;
            if (pend_v_q) rdata_q <= cdata_rd_i;
        end
    end

    assign r0_gnt_o    = gnt0;
    assign r1_gnt_o    = gnt1;
    assign r0_rvalid_o = r0_rvalid_q;
    assign r1_rvalid_o = r1_rvalid_q;
    assign rdata_o     = rdata_q;
    assign crd_o       = crd_q;
    assign cwr_o       = cwr_q;
    assign csel_o      = csel_q;
    assign caddr_rd_o  = caddr_rd_q;
    assign caddr_wr_o  = caddr_wr_q;
    assign cdata_wr_o  = cdata_wr_q;

endmodule

// File: tb/tb_layer_mem_arb.sv
// Bench for layer_mem_arb: grant tables, hand-written corner sequences and a
// randomized run checked against a behavioural arbiter/memory model.
module tb_layer_mem_arb;

    localparam int AW    = 12;
    localparam int DW    = 13;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_req = 0, r0_we = 0, r0_sel = 0, r1_req = 0, r1_we = 0, r1_sel = 0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] rdata, cdata_wr;
    logic [DW-1:0] cdata_rd = '0;
    logic          crd, cwr, csel;
    logic [AW-1:0] caddr_rd, caddr_wr;

    int n_pass = 0;
    int n_total = 0;

    layer_mem_arb #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_sel_i(r0_sel), .r0_addr_i(r0_addr),
        .r0_wdata_i(r0_wdata), .r0_gnt_o(r0_gnt), .r0_rvalid_o(r0_rvalid),
        .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_sel_i(r1_sel), .r1_addr_i(r1_addr),
        .r1_wdata_i(r1_wdata), .r1_gnt_o(r1_gnt), .r1_rvalid_o(r1_rvalid),
        .rdata_o(rdata), .crd_o(crd), .cwr_o(cwr), .csel_o(csel),
        .caddr_rd_o(caddr_rd), .caddr_wr_o(caddr_wr), .cdata_wr_o(cdata_wr),
        .cdata_rd_i(cdata_rd)
    );

    always #5 clk = ~clk;

    // External layer memory: commits writes on the rising edge, drives reads on the falling edge.
    logic [DW-1:0] mem [0:1][0:4095];
    logic          mem_clr = 1'b0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int s = 0; s < 2; s++) for (int a = 0; a < 8; a++) mem[s][a] <= '0;
        end else if (cwr) begin
            mem[csel][caddr_wr] <= cdata_wr;
        end
    end
    always @(negedge clk) if (crd) cdata_rd <= mem[csel][caddr_rd];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int n, input bit rq, input bit we, input bit sel,
                          input int addr, input int wd);
        if (n == 0) begin
            r0_req = rq; r0_we = we; r0_sel = sel; r0_addr = AW'(addr); r0_wdata = DW'(wd);
        end else begin
            r1_req = rq; r1_we = we; r1_sel = sel; r1_addr = AW'(addr); r1_wdata = DW'(wd);
        end
    endtask

    typedef struct {bit q0; bit q1; bit g0; bit g1;} vec_t;
    vec_t tbl[$];

    typedef struct {int id; int data; int due;} rd_t;
    rd_t rq_q[$];

    // Random-phase request state and reference model.
    bit  rq[2], rwe[2], rsel[2];
    int  raddr[2], rwd[2];
    int  own, run, cyc, g;
    int  mm [0:1][0:7];

    initial begin
        for (int s = 0; s < 2; s++) for (int a = 0; a < 4096; a++) mem[s][a] = '0;
        tick(); tick();
        rst_n = 1'b1;

        // Build up non-reset state, then reset mid-cycle.
        set_op(0, 1, 1, 1, 5, 'h1AB); tick();
        set_op(0, 0, 0, 0, 0, 0); set_op(1, 1, 0, 1, 5, 0); tick();
        set_op(1, 0, 0, 0, 0, 0); tick();
        chk("pre_rvalid1", r1_rvalid, 1);
        chk("pre_rdata", rdata, 'h1AB);
        set_op(0, 1, 1, 1, 6, 'h0F0); tick();
        chk("pre_cwr", cwr, 1);
        set_op(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {crd, cwr, csel, r0_rvalid, r1_rvalid, r0_gnt, r1_gnt}, 0);
        chk("rst_caddr_rd", caddr_rd, 0);
        chk("rst_caddr_wr", caddr_wr, 0);
        chk("rst_cdata_wr", cdata_wr, 0);
        chk("rst_rdata", rdata, 0);
        #1 rst_n = 1'b1;
        set_op(1, 1, 0, 0, 0, 0);
        #1;
        chk("rel_r1_gnt", r1_gnt, 1);
        chk("rel_r0_gnt", r0_gnt, 0);
        tick();
        set_op(1, 0, 0, 0, 0, 0); tick(); tick();

        // Single-requester write stream, no bubbles.
        for (int i = 0; i < 4; i++) begin
            set_op(0, 1, 1, 0, i, 'h10 + i);
            #1 chk("ws_gnt", r0_gnt, 1);
            tick();
            chk("ws_cwr", {cwr, crd}, 2'b10);
            chk("ws_addr", caddr_wr, i);
            chk("ws_data", cdata_wr, 'h10 + i);
        end

        // Read-after-write: overwrite addr 2 and read it the very next cycle.
        set_op(0, 1, 1, 0, 2, 'h55); tick();
        set_op(0, 1, 1, 0, 2, 'h12); tick();
        set_op(0, 0, 0, 0, 0, 0); set_op(1, 1, 0, 0, 2, 0); tick();
        chk("raw_crd", crd, 1);
        chk("raw_early", {r0_rvalid, r1_rvalid}, 0);
        set_op(1, 0, 0, 0, 0, 0); tick();
        chk("raw_rvalid", {r0_rvalid, r1_rvalid}, 2'b01);
        chk("raw_rdata", rdata, 'h12);
        tick();
        chk("raw_rvalid_drop", {r0_rvalid, r1_rvalid}, 0);

        // Fresh reset so the grant table starts from prio=0, cnt=0.
        #1 rst_n = 1'b0; #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) tbl.push_back('{1, 1, (i / 4) != 1, (i / 4) == 1});
        tbl.push_back('{0, 0, 0, 0});
        for (int i = 0; i < 10; i++) tbl.push_back('{1, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 1});
        tbl.push_back('{1, 1, 0, 1});
        for (int i = 0; i < tbl.size(); i++) begin
            set_op(0, tbl[i].q0, 1, 0, 7, i);
            set_op(1, tbl[i].q1, 1, 0, 6, i);
            #1;
            chk($sformatf("tbl[%0d]", i), {r0_gnt, r1_gnt}, {tbl[i].g0, tbl[i].g1});
            chk("tbl_excl", r0_gnt & r1_gnt, 0);
            tick();
        end

        // Reset while a read is in flight: no rvalid, arbitration restarts from r0.
        set_op(0, 0, 0, 0, 0, 0); set_op(1, 1, 0, 0, 7, 0); tick();
        chk("rdr_crd", crd, 1);
        set_op(1, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0; #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdr_no_rvalid", {r0_rvalid, r1_rvalid}, 0);
        end
        set_op(0, 1, 1, 0, 4, 1); set_op(1, 1, 1, 0, 5, 2);
        for (int i = 0; i < 5; i++) begin
            #1 chk("rdr_gnt", {r0_gnt, r1_gnt}, (i < 4) ? 2'b10 : 2'b01);
            tick();
        end
        set_op(0, 0, 0, 0, 0, 0); set_op(1, 0, 0, 0, 0, 0);

        // Randomized run against the reference model.
        #1 rst_n = 1'b0; #1 rst_n = 1'b1;
        mem_clr = 1'b1; tick(); mem_clr = 1'b0;
        own = 0; run = 0; cyc = 0;
        for (int s = 0; s < 2; s++) for (int a = 0; a < 8; a++) mm[s][a] = 0;
        for (int n = 0; n < 2; n++) rq[n] = 0;
        for (int it = 0; it < 1500; it++) begin
            @(negedge clk);
            g = -1;
            if (rq[0] && rq[1]) g = (run < BURST) ? own : 1 - own;
            else if (rq[0]) g = 0;
            else if (rq[1]) g = 1;
            chk("rnd_gnt", {r0_gnt, r1_gnt}, {g == 0, g == 1});
            @(posedge clk); #1;
            cyc++;
            if (rq_q.size() > 0 && rq_q[0].due == cyc) begin
                chk("rnd_rvalid", {r0_rvalid, r1_rvalid}, {rq_q[0].id == 0, rq_q[0].id == 1});
                chk("rnd_rdata", rdata, rq_q[0].data);
                void'(rq_q.pop_front());
            end else begin
                chk("rnd_rvalid_idle", {r0_rvalid, r1_rvalid}, 0);
            end
            if (g >= 0) begin
                if (g == own) run++;
                else begin own = g; run = 1; end
                chk("rnd_csel", csel, rsel[g]);
                if (rwe[g]) begin
                    mm[rsel[g]][raddr[g]] = rwd[g];
                    chk("rnd_wr_ctl", {cwr, crd}, 2'b10);
                    chk("rnd_caddr_wr", caddr_wr, raddr[g]);
                    chk("rnd_cdata_wr", cdata_wr, rwd[g]);
                end else begin
                    rq_q.push_back('{g, mm[rsel[g]][raddr[g]], cyc + 1});
                    chk("rnd_rd_ctl", {cwr, crd}, 2'b01);
                    chk("rnd_caddr_rd", caddr_rd, raddr[g]);
                end
            end else begin
                run = 0;
                chk("rnd_idle_ctl", {cwr, crd}, 0);
            end
            for (int n = 0; n < 2; n++) begin
                if (!rq[n] || g == n) begin
                    rq[n]    = (it < 1490) && ($urandom_range(0, 3) != 0);
                    rwe[n]   = 1'($urandom_range(0, 1));
                    rsel[n]  = 1'($urandom_range(0, 1));
                    raddr[n] = $urandom_range(0, 7);
                    rwd[n]   = $urandom_range(0, 8191);
                end
                set_op(n, rq[n], rwe[n], rsel[n], raddr[n], rwd[n]);
            end
        end
        chk("rnd_drained", rq_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layer_mem_arb.md
# layer_mem_arb

Two-requester arbiter and sequencer for the shared layer memory port (`crd`/`cwr`/`csel`/`caddr_rd`/`caddr_wr`/`cdata_wr`/`cdata_rd`) used by the CONV5x5 flow. Requester 0 is the convolution engine, which writes layer 0. Requester 1 is the pooling engine, which reads layer 0 and writes layer 1. The block issues one memory operation per cycle and uses burst-limited round-robin arbitration. It registers all memory-side outputs and returns read data with a fixed latency.

## Interface
- `AW`, default 12: address width.
- `DW`, default 13: data width.
- `BURST`, default 4: maximum consecutive grants to one requester while the other is requesting; range 1..15.
- `clk` in 1: clock; all logic acts on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rN_req` in 1 (N=0,1): operation request. `rN_we`, `rN_sel`, `rN_addr`, `rN_wdata` must be held stable while `rN_req`=1 and `rN_gnt`=0.
- `rN_we` in 1: 1 = write, 0 = read.
- `rN_sel` in 1: memory select, driven to `csel` (0 = layer 0, 1 = layer 1).
- `rN_addr` in AW: address.
- `rN_wdata` in DW: write data.
- `rN_gnt` out 1: combinational grant. An operation is accepted on a rising edge where `rN_req`=1 and `rN_gnt`=1.
- `rN_rvalid` out 1: registered; `rdata` is valid for requester N in this cycle.
- `rdata` out DW: registered read data, shared by both requesters.
- `crd`, `cwr`, `csel` out 1 each: registered memory controls.
- `caddr_rd`, `caddr_wr` out AW: registered memory addresses.
- `cdata_wr` out DW: registered memory write data.
- `cdata_rd` in DW: memory read data. The memory drives it on the falling edge of a cycle in which `crd`=1.

## Operation
- State:
  - `prio` (1 bit): preferred requester.
  - `cnt` (4 bits): consecutive grants to `prio`.
  - One-entry read-tag pipeline: `pend_v`, `pend_id`.
- Grant rules, evaluated combinationally from `req` and state:
  - No request: no grant.
  - One requester active: grant it.
  - Both active, `cnt` < `BURST`: grant `prio`.
  - Both active, `cnt` = `BURST`: grant `~prio`.
- State update on each rising edge:
  - Accept by `prio`: `cnt` <= `cnt`+1, saturating at `BURST`.
  - Accept by `~prio`: `prio` <= granted id, `cnt` <= 1.
  - No accept: `prio` holds, `cnt` <= 0.
- At most one grant per cycle; `r0_gnt` and `r1_gnt` are never both 1.
- On an accepted write, register `cwr`=1, `crd`=0, `csel`=`sel`, `caddr_wr`=`addr`, `cdata_wr`=`wdata`.
- On an accepted read, register `crd`=1, `cwr`=0, `csel`=`sel`, `caddr_rd`=`addr`, `pend_v`=1, `pend_id`=requester.
- With no accept, `crd`=`cwr`=0. Addresses, `cdata_wr` and `csel` hold their last values.
- On the edge after a read is issued, `rdata` <= `cdata_rd`, `rN_rvalid` <= (`pend_v` and `pend_id`=N), and `pend_v` <= the new read accept.
- Ordering is program order per port. A read accepted one cycle after a write to the same address returns the new data, because the memory commits the write before the read's falling-edge fetch.

## Timing
- Values on `reset`=0, applied immediately and asynchronously:
  - `crd`=`cwr`=0, `csel`=0, `caddr_rd`=`caddr_wr`=0, `cdata_wr`=0.
  - `rdata`=0, `r0_rvalid`=`r1_rvalid`=0.
  - `prio`=0, `cnt`=0, `pend_v`=0.
  - `rN_gnt` follows from this state and the current `req`.
- Write: accepted at edge E, `cwr` high in cycle E..E+1, memory commits at E+1.
- Read: accepted at edge E, `crd` high in cycle E..E+1, `cdata_rd` captured at E+1, `rvalid`/`rdata` valid in cycle E+1..E+2. Read latency is 2 edges.
- Throughput is 1 operation per cycle, including back-to-back reads, back-to-back writes, and alternating requesters.
- Reset asserted mid-operation drops any in-flight read: no `rvalid` is issued for it.
- The first accept after reset with both requesting goes to r0.

## Test plan
- **Reset values:** assert `reset`=0 mid-cycle with `req` idle -> all outputs 0 immediately. Release `reset`, then assert `r1_req` -> `r1_gnt`=1 in the same cycle.
- **Single-requester write stream:** r0 writes `sel`=0 to addr 0..3 with data 0x10..0x13 on 4 consecutive edges -> `cwr`=1 for 4 consecutive cycles, `caddr_wr`=0,1,2,3, `cdata_wr`=0x10..0x13, no bubbles.
- **Read latency and read-after-write:** r1 reads addr 2 one cycle after r0's write of 0x12 to addr 2 -> `r1_rvalid`=1 exactly 2 edges after the accept, `rdata`=0x12, `r0_rvalid` stays 0.
- **Contention, BURST=4:** both `req` held high for 12 cycles -> grant sequence 0,0,0,0,1,1,1,1,0,0,0,0, never both `gnt` high.
- **Burst counter behaviour:** r0 alone for 10 cycles -> all 10 granted. Then r1 joins -> r1 is granted on the next edge, because `cnt` saturated at `BURST`.
- **Reset during read:** assert `reset`=0 in the cycle `crd`=1 -> `rvalid` never asserted for that read. After release, `prio`=0 and `cnt`=0.
